// File: rtl/adc_readout.sv
// adc_readout: turns each rising edge of flag_adc into one conversion on a
// 16-bit serial ADC (CNV/SCLK/SDO, MSB first). Captured words are queued in
// a small FIFO that the host drains a byte at a time, high byte first.
//
// Optional feature: define ADC_READOUT_TESTPAT_EN to push a free-running
// DATA_W-bit counter instead of the shifted ADC data. The CNV/SCLK sequence
// runs unchanged.
//
// Ports:
//   clk, rst        system clock, asynchronous active-high reset
//   flag_adc        conversion trigger (rising-edge detected)
//   adc_cnv         ADC convert-start, high for CONV_CYCLES clocks
//   adc_sclk        ADC serial clock, idles low
//   adc_sdo         ADC serial data, sampled on SCLK rise
//   rd              host read strobe, one byte per high cycle
//   clr             synchronous flush of FIFO and sticky flags
//   dout            current read byte (0 while empty)
//   empty, full     FIFO status
//   overflow        sticky: a captured word was dropped, FIFO full
//   trig_miss       sticky: trigger edge arrived while busy
//   busy            conversion sequence in progress
module adc_readout #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned SCLK_DIV    = 4,
  parameter int unsigned CONV_CYCLES = 40,
  parameter int unsigned ADDR_W      = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flag_adc,
  output logic       adc_cnv,
  output logic       adc_sclk,
  input  logic       adc_sdo,
  input  logic       rd,
  input  logic       clr,
  output logic [7:0] dout,
  output logic       empty,
  output logic       full,
  output logic       overflow,
  output logic       trig_miss,
  output logic       busy
);

  localparam int unsigned DEPTH   = 1 << ADDR_W;
  localparam int unsigned PTR_W   = ADDR_W + 1;
  localparam int unsigned CNT_MAX = (CONV_CYCLES > SCLK_DIV) ? CONV_CYCLES : SCLK_DIV;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned BIT_W   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CONV  = 2'd1,
    S_SHIFT = 2'd2,
    S_PUSH  = 2'd3
  } state_t;

  // Sequencer state
  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIT_W-1:0]    r_bit;
  logic [DATA_W-1:0]   r_shift;
  logic                r_cnv;
  logic                r_sclk;
  logic                r_busy;
  logic                r_flag_d;

  // FIFO and read-side state
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [PTR_W-1:0]    r_wr_ptr;
  logic                r_empty;
  logic                r_full;
  logic                r_byte_sel;
  logic [7:0]          r_dout;
  logic                r_overflow;
  logic                r_trig_miss;

  logic                w_trig;
  logic [DATA_W-1:0]   w_word;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic [PTR_W-1:0]    w_rd_ptr_nxt;
  logic [PTR_W-1:0]    w_wr_ptr_nxt;
  logic                w_empty_nxt;
  logic                w_full_nxt;
  logic                w_byte_sel_nxt;
  logic [DATA_W-1:0]   w_head_nxt;
  logic [7:0]          w_dout_nxt;

  assign w_trig = flag_adc & ~r_flag_d;

`ifdef ADC_READOUT_TESTPAT_EN
  // Test-pattern counter; advances on every PUSH, dropped or not
  logic [DATA_W-1:0] r_tp_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tp_cnt <= '0;
    end else if (r_state == S_PUSH) begin
      r_tp_cnt <= r_tp_cnt + DATA_W'(1);
    end
  end

  assign w_word = r_tp_cnt;
`else
  assign w_word = r_shift;
`endif

  // Conversion sequencer: CNV pulse, then DATA_W SCLK periods, then one PUSH cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_cnv   <= 1'b0;
      r_sclk  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_state <= S_CONV;
            r_cnv   <= 1'b1;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
          end
        end
        S_CONV: begin
          if (r_cnt == CNT_W'(CONV_CYCLES - 1)) begin
            r_state <= S_SHIFT;
            r_cnv   <= 1'b0;
            r_sclk  <= 1'b0;
            r_cnt   <= '0;
            r_bit   <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_SHIFT: begin
          if (r_cnt == CNT_W'(SCLK_DIV - 1)) begin
            r_cnt <= '0;
            if (!r_sclk) begin
              // SDO is captured on the same edge that raises SCLK
              r_sclk  <= 1'b1;
              r_shift <= {r_shift[DATA_W-2:0], adc_sdo};
            end else begin
              r_sclk <= 1'b0;
              if (r_bit == BIT_W'(DATA_W - 1)) begin
                r_state <= S_PUSH;
              end else begin
                r_bit <= r_bit + BIT_W'(1);
              end
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_PUSH: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_cnv   <= 1'b0;
          r_sclk  <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // FIFO next-state; a pop in the PUSH cycle frees the slot before the write
  always_comb begin
    w_pop          = 1'b0;
    w_push         = 1'b0;
    w_drop         = 1'b0;
    w_rd_ptr_nxt   = r_rd_ptr;
    w_wr_ptr_nxt   = r_wr_ptr;
    w_byte_sel_nxt = r_byte_sel;
    w_head_nxt     = '0;
    w_dout_nxt     = 8'h00;

    if (clr) begin
      w_rd_ptr_nxt   = '0;
      w_wr_ptr_nxt   = '0;
      w_byte_sel_nxt = 1'b0;
    end else begin
      w_pop  = rd & ~r_empty & r_byte_sel;
      w_push = (r_state == S_PUSH) & (~r_full | w_pop);
      w_drop = (r_state == S_PUSH) & r_full & ~w_pop;
      if (rd && !r_empty) begin
        w_byte_sel_nxt = ~r_byte_sel;
      end
      w_rd_ptr_nxt = r_rd_ptr + PTR_W'(w_pop);
      w_wr_ptr_nxt = r_wr_ptr + PTR_W'(w_push);
    end

    w_empty_nxt = (w_rd_ptr_nxt == w_wr_ptr_nxt);
    w_full_nxt  = (w_rd_ptr_nxt[ADDR_W] != w_wr_ptr_nxt[ADDR_W]) &&
                  (w_rd_ptr_nxt[ADDR_W-1:0] == w_wr_ptr_nxt[ADDR_W-1:0]);

    // Head after this edge: bypass the word being written if it lands at the head
    if (w_push && (r_wr_ptr[ADDR_W-1:0] == w_rd_ptr_nxt[ADDR_W-1:0])) begin
      w_head_nxt = w_word;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt[ADDR_W-1:0]];
    end

    if (!w_empty_nxt) begin
      w_dout_nxt = w_byte_sel_nxt ? w_head_nxt[7:0] : w_head_nxt[DATA_W-1 -: 8];
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= w_word;
    end
  end

  // FIFO pointers, status, read byte and sticky flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_flag_d    <= 1'b0;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_empty     <= 1'b1;
      r_full      <= 1'b0;
      r_byte_sel  <= 1'b0;
      r_dout      <= 8'h00;
      r_overflow  <= 1'b0;
      r_trig_miss <= 1'b0;
    end else begin
      r_flag_d   <= flag_adc;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_empty    <= w_empty_nxt;
      r_full     <= w_full_nxt;
      r_byte_sel <= w_byte_sel_nxt;
      r_dout     <= w_dout_nxt;
      if (clr) begin
        r_overflow  <= 1'b0;
        r_trig_miss <= 1'b0;
      end else begin
        if (w_drop) begin
          r_overflow <= 1'b1;
        end
        if (w_trig && (r_state != S_IDLE)) begin
          r_trig_miss <= 1'b1;
        end
      end
    end
  end

  assign adc_cnv   = r_cnv;
  assign adc_sclk  = r_sclk;
  assign busy      = r_busy;
  assign dout      = r_dout;
  assign empty     = r_empty;
  assign full      = r_full;
  assign overflow  = r_overflow;
  assign trig_miss = r_trig_miss;

endmodule

// File: tb/tb_adc_readout.sv
// Testbench for adc_readout: behavioural serial ADC plus a word-queue model
// of the FIFO; every scenario compares DUT outputs against that model.
module tb_adc_readout;

  localparam int DW    = 16;
  localparam int DEPTH = 16;

  logic       clk;
  logic       rst;
  logic       flag_adc;
  logic       adc_cnv;
  logic       adc_sclk;
  logic       adc_sdo;
  logic       rd;
  logic       clr;
  logic [7:0] dout;
  logic       empty;
  logic       full;
  logic       overflow;
  logic       trig_miss;
  logic       busy;

  adc_readout dut (
    .clk       (clk),
    .rst       (rst),
    .flag_adc  (flag_adc),
    .adc_cnv   (adc_cnv),
    .adc_sclk  (adc_sclk),
    .adc_sdo   (adc_sdo),
    .rd        (rd),
    .clr       (clr),
    .dout      (dout),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .trig_miss (trig_miss),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural ADC: MSB presented when CNV falls, next bit on each SCLK fall
  logic [DW-1:0] adc_word = '0;
  int            fall_cnt = 0;
  int            rise_cnt = 0;

  always @(negedge adc_sclk or posedge adc_cnv) begin
    if (adc_cnv) fall_cnt = 0;
    else         fall_cnt = fall_cnt + 1;
  end

  always @(posedge adc_sclk or posedge adc_cnv) begin
    if (adc_cnv) rise_cnt = 0;
    else         rise_cnt = rise_cnt + 1;
  end

  always_comb begin
    adc_sdo = 1'b0;
    if (fall_cnt >= 0 && fall_cnt < DW) adc_sdo = adc_word[DW-1-fall_cnt];
  end

  // Reference model: queue of stored words, sticky overflow, pattern counter
  logic [DW-1:0] mq[$];
  bit            m_ovf = 1'b0;
  int            m_tp  = 0;

  function automatic logic [DW-1:0] model_word(input logic [DW-1:0] w);
`ifdef ADC_READOUT_TESTPAT_EN
    return DW'(m_tp);
`else
    return w;
`endif
  endfunction

  // One completed conversion as seen by the model
  task automatic model_conv(input logic [DW-1:0] w, input bit discard);
    logic [DW-1:0] ew;
    ew = model_word(w);
    m_tp = m_tp + 1;
    if (!discard) begin
      if (mq.size() < DEPTH) mq.push_back(ew);
      else                   m_ovf = 1'b1;
    end
  endtask

  // All tasks start and end just after a falling clock edge
  task automatic fire(input bit hold);
    flag_adc = 1'b1;
    @(negedge clk);
    if (!hold) flag_adc = 1'b0;
  endtask

  task automatic pulse_rd();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic read_word(output logic [DW-1:0] w);
    logic [7:0] hi;
    logic [7:0] lo;
    hi = dout;
    pulse_rd();
    lo = dout;
    pulse_rd();
    w = {hi, lo};
  endtask

  task automatic conv(input logic [DW-1:0] w, input int spacing);
    adc_word = w;
    fire(1'b0);
    repeat (spacing) @(negedge clk);
    model_conv(w, 1'b0);
  endtask

  task automatic test_reset();
    n_tests++; if (adc_cnv !== 1'b0)   begin n_fail++; $display("FAIL reset_cnv got %b want 0", adc_cnv); end
    n_tests++; if (adc_sclk !== 1'b0)  begin n_fail++; $display("FAIL reset_sclk got %b want 0", adc_sclk); end
    n_tests++; if (dout !== 8'h00)     begin n_fail++; $display("FAIL reset_dout got %h want 00", dout); end
    n_tests++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL reset_empty got %b want 1", empty); end
    n_tests++; if (full !== 1'b0)      begin n_fail++; $display("FAIL reset_full got %b want 0", full); end
    n_tests++; if (overflow !== 1'b0)  begin n_fail++; $display("FAIL reset_overflow got %b want 0", overflow); end
    n_tests++; if (trig_miss !== 1'b0) begin n_fail++; $display("FAIL reset_trig_miss got %b want 0", trig_miss); end
    n_tests++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
  endtask

  task automatic test_single();
    logic [DW-1:0] ew;
    adc_word = 16'hA5C3;
    fire(1'b0);
    for (int k = 0; k <= 170; k++) begin
      if (k == 0) begin
        n_tests++; if (busy !== 1'b1)    begin n_fail++; $display("FAIL single_busy_rise got %b want 1", busy); end
        n_tests++; if (adc_cnv !== 1'b1) begin n_fail++; $display("FAIL single_cnv_rise got %b want 1", adc_cnv); end
      end
      if (k == 39) begin
        n_tests++; if (adc_cnv !== 1'b1) begin n_fail++; $display("FAIL single_cnv_hold got %b want 1", adc_cnv); end
      end
      if (k == 40) begin
        n_tests++; if (adc_cnv !== 1'b0) begin n_fail++; $display("FAIL single_cnv_fall got %b want 0", adc_cnv); end
      end
      if (k == 43) begin
        n_tests++; if (adc_sclk !== 1'b0) begin n_fail++; $display("FAIL single_sclk_low got %b want 0", adc_sclk); end
      end
      if (k == 44) begin
        n_tests++; if (adc_sclk !== 1'b1) begin n_fail++; $display("FAIL single_sclk_rise got %b want 1", adc_sclk); end
      end
      if (k == 168) begin
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_early got %b want 1", empty); end
      end
      if (k == 169) begin
        n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL single_empty_fall got %b want 0", empty); end
        n_tests++; if (adc_sclk !== 1'b0) begin n_fail++; $display("FAIL single_sclk_idle got %b want 0", adc_sclk); end
      end
      if (k == 170) begin
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_fall got %b want 0", busy); end
      end
      if (k < 170) @(negedge clk);
    end
    n_tests++; if (rise_cnt !== DW) begin n_fail++; $display("FAIL single_sclk_rises got %0d want %0d", rise_cnt, DW); end
    model_conv(16'hA5C3, 1'b0);
    ew = mq.pop_front();
    n_tests++; if (dout !== ew[15:8]) begin n_fail++; $display("FAIL single_dout_hi got %h want %h", dout, ew[15:8]); end
    pulse_rd();
    n_tests++; if (dout !== ew[7:0]) begin n_fail++; $display("FAIL single_dout_lo got %h want %h", dout, ew[7:0]); end
    pulse_rd();
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty_after got %b want 1", empty); end
    n_tests++; if (dout !== 8'h00) begin n_fail++; $display("FAIL single_dout_empty got %h want 00", dout); end
  endtask

  task automatic test_hold();
    logic [DW-1:0] w;
    logic [DW-1:0] got;
    logic [DW-1:0] ew;
    w = DW'($urandom);
    adc_word = w;
    fire(1'b1);
    repeat (300) @(negedge clk);
    flag_adc = 1'b0;
    @(negedge clk);
    model_conv(w, 1'b0);
    n_tests++; if (trig_miss !== 1'b0) begin n_fail++; $display("FAIL hold_trig_miss got %b want 0", trig_miss); end
    ew = mq.pop_front();
    read_word(got);
    n_tests++; if (got !== ew) begin n_fail++; $display("FAIL hold_word got %h want %h", got, ew); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL hold_one_word got empty=%b want 1", empty); end
  endtask

  task automatic test_miss();
    logic [DW-1:0] w;
    logic [DW-1:0] got;
    logic [DW-1:0] ew;
    w = DW'($urandom);
    adc_word = w;
    fire(1'b0);
    repeat (99) @(negedge clk);
    flag_adc = 1'b1;
    @(negedge clk);
    flag_adc = 1'b0;
    n_tests++; if (trig_miss !== 1'b1) begin n_fail++; $display("FAIL miss_flag got %b want 1", trig_miss); end
    repeat (200) @(negedge clk);
    model_conv(w, 1'b0);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL miss_no_restart got busy=%b want 0", busy); end
    ew = mq.pop_front();
    read_word(got);
    n_tests++; if (got !== ew) begin n_fail++; $display("FAIL miss_word got %h want %h", got, ew); end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL miss_one_word got empty=%b want 1", empty); end
  endtask

  task automatic test_rst_mid();
    logic [DW-1:0] w;
    logic [DW-1:0] got;
    logic [DW-1:0] ew;
    adc_word = DW'($urandom);
    fire(1'b0);
    repeat (60) @(negedge clk);
    n_tests++; if (adc_sclk !== 1'b1) begin n_fail++; $display("FAIL rstmid_sclk_pre got %b want 1", adc_sclk); end
    #1 rst = 1'b1;
    #1;
    n_tests++; if (adc_sclk !== 1'b0) begin n_fail++; $display("FAIL rstmid_sclk got %b want 0", adc_sclk); end
    n_tests++; if (adc_cnv !== 1'b0)  begin n_fail++; $display("FAIL rstmid_cnv got %b want 0", adc_cnv); end
    n_tests++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    m_tp  = 0;
    n_tests++; if (empty !== 1'b1)     begin n_fail++; $display("FAIL rstmid_empty got %b want 1", empty); end
    n_tests++; if (trig_miss !== 1'b0) begin n_fail++; $display("FAIL rstmid_trig_miss got %b want 0", trig_miss); end
    w = DW'($urandom);
    conv(w, 172);
    ew = mq.pop_front();
    read_word(got);
    n_tests++; if (got !== ew) begin n_fail++; $display("FAIL rstmid_next_word got %h want %h", got, ew); end
  endtask

  task automatic test_fill();
    logic [DW-1:0] got;
    logic [DW-1:0] ew;
    for (int i = 1; i <= DEPTH + 1; i++) begin
      conv(DW'($urandom), 200);
      if (i == DEPTH) begin
        n_tests++; if (full !== 1'b1)     begin n_fail++; $display("FAIL fill_full got %b want 1", full); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_no_ovf got %b want 0", overflow); end
      end
    end
    n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL fill_overflow got %b want %b", overflow, m_ovf); end
    n_tests++; if (full !== 1'b1)      begin n_fail++; $display("FAIL fill_full_after got %b want 1", full); end
    for (int i = 0; i < DEPTH; i++) begin
      ew = mq.pop_front();
      read_word(got);
      n_tests++; if (got !== ew) begin n_fail++; $display("FAIL fill_word%0d got %h want %h", i, got, ew); end
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fill_drained got empty=%b want 1", empty); end
  endtask

  task automatic test_clr();
    n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL clr_ovf_pre got %b want 1", overflow); end
    conv(DW'($urandom), 172);
    n_tests++; if (empty !== 1'b0) begin n_fail++; $display("FAIL clr_pre_empty got %b want 0", empty); end
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    n_tests++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL clr_empty got %b want 1", empty); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL clr_overflow got %b want 0", overflow); end
    n_tests++; if (dout !== 8'h00)    begin n_fail++; $display("FAIL clr_dout got %h want 00", dout); end
    // clr landing in the PUSH cycle discards that word
    adc_word = DW'($urandom);
    fire(1'b0);
    repeat (168) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_conv(adc_word, 1'b1);
    @(negedge clk);
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL clr_push_discard got empty=%b want 1", empty); end
  endtask

  task automatic test_pop_push();
    logic [DW-1:0] got;
    logic [DW-1:0] ew;
    for (int i = 0; i < DEPTH; i++) conv(DW'($urandom), 172);
    n_tests++; if (full !== 1'b1) begin n_fail++; $display("FAIL pp_full_pre got %b want 1", full); end
    ew = mq[0];
    pulse_rd();
    n_tests++; if (dout !== ew[7:0]) begin n_fail++; $display("FAIL pp_lo_byte got %h want %h", dout, ew[7:0]); end
    adc_word = DW'($urandom);
    fire(1'b0);
    repeat (168) @(negedge clk);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    void'(mq.pop_front());
    model_conv(adc_word, 1'b0);
    n_tests++; if (full !== 1'b1)     begin n_fail++; $display("FAIL pp_full_kept got %b want 1", full); end
    n_tests++; if (overflow !== m_ovf) begin n_fail++; $display("FAIL pp_no_overflow got %b want %b", overflow, m_ovf); end
    for (int i = 0; i < DEPTH; i++) begin
      ew = mq.pop_front();
      read_word(got);
      n_tests++; if (got !== ew) begin n_fail++; $display("FAIL pp_word%0d got %h want %h", i, got, ew); end
    end
    n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL pp_drained got empty=%b want 1", empty); end
  endtask

  initial begin
    rst      = 1'b1;
    flag_adc = 1'b0;
    rd       = 1'b0;
    clr      = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single();
    test_hold();
    test_miss();
    test_rst_mid();
    test_fill();
    test_clr();
    test_pop_push();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
